// File: rtl/vadar_uart_pkg.sv
// Shared constants, tx framer state encoding and frame-length helper for the
// hash UART transmit path.
package vadar_uart_pkg;

   localparam logic [7:0] TERM_BYTE     = 8'h2C;
   localparam logic [7:0] FOUND_CHAR    = 8'h59;
   localparam logic [7:0] NOTFOUND_CHAR = 8'h4E;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PREP      = 2'd1,
      SEND      = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_t;

   // Bytes on the wire: status + payload (doubled in hex mode) + terminator.
   function automatic int unsigned frame_len(input int unsigned num_bytes, input logic hex_en);
      if (hex_en) begin
         return (32'd2 * num_bytes) + 32'd2;
      end else begin
         return num_bytes + 32'd2;
      end
   endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Converts a 4-bit nibble into its upper-case ASCII hex character.
module hex_nibble_ascii (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   // '0'..'9' sit at 0x30, 'A'..'F' start at 0x41 (0x37 + 10).
   always_comb begin
      ascii = 8'h00;
      if (nibble < 4'd10) begin
         ascii = 8'h30 + {4'h0, nibble};
      end else begin
         ascii = 8'h37 + {4'h0, nibble};
      end
   end

endmodule

// File: rtl/hash_tx_framer.sv
// Serialises a captured hash word and found flag into a framed UART byte stream.
// Optional macro HASH_TX_HEX_EN sends each payload byte as two ASCII hex chars.
module hash_tx_framer #(
   parameter int unsigned NUM_BYTES     = 16,
   parameter logic [7:0]  TERM_BYTE     = vadar_uart_pkg::TERM_BYTE,
   parameter logic [7:0]  FOUND_CHAR    = vadar_uart_pkg::FOUND_CHAR,
   parameter logic [7:0]  NOTFOUND_CHAR = vadar_uart_pkg::NOTFOUND_CHAR
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [NUM_BYTES*8-1:0] Data,
   input  logic                   Found,
   output logic                   Busy,
   output logic                   Done,
   output logic [7:0]             Tx_Data,
   output logic                   Tx_Send,
   input  logic                   Tx_Busy
);
   import vadar_uart_pkg::*;

   localparam int unsigned DATA_W = NUM_BYTES * 8;
   localparam int unsigned IDX_W  = $clog2((2 * NUM_BYTES) + 3);
`ifdef HASH_TX_HEX_EN
   localparam logic HEX_MODE = 1'b1;
`else
   localparam logic HEX_MODE = 1'b0;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frame_len(NUM_BYTES, HEX_MODE) - 32'd1);

   tx_state_t         state;
   logic [DATA_W-1:0] shreg;
   logic              found_r;
   logic [IDX_W-1:0]  idx;
   logic [7:0]        payload_byte;
   logic [7:0]        cur_byte;
   logic              is_payload;

`ifdef HASH_TX_HEX_EN
   logic       nib_phase;
   logic [3:0] nibble;

   assign nibble = nib_phase ? shreg[DATA_W-5 -: 4] : shreg[DATA_W-1 -: 4];

   hex_nibble_ascii u_hex (
      .nibble (nibble),
      .ascii  (payload_byte)
   );
`else
   assign payload_byte = shreg[DATA_W-1 -: 8];
`endif

   assign is_payload = (idx != {IDX_W{1'b0}}) && (idx != LAST_IDX);

   // Pick the byte for the current index: status, payload or terminator.
   always_comb begin
      cur_byte = payload_byte;
      if (idx == {IDX_W{1'b0}}) begin
         cur_byte = found_r ? FOUND_CHAR : NOTFOUND_CHAR;
      end else if (idx == LAST_IDX) begin
         cur_byte = TERM_BYTE;
      end else begin
         cur_byte = payload_byte;
      end
   end

   // Frame sequencer with registered handshake and status outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         shreg   <= {DATA_W{1'b0}};
         found_r <= 1'b0;
         idx     <= {IDX_W{1'b0}};
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Tx_Data <= 8'h00;
         Tx_Send <= 1'b0;
`ifdef HASH_TX_HEX_EN
         nib_phase <= 1'b0;
`endif
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  shreg   <= Data;
                  found_r <= Found;
                  idx     <= {IDX_W{1'b0}};
                  Busy    <= 1'b1;
                  state   <= PREP;
`ifdef HASH_TX_HEX_EN
                  nib_phase <= 1'b0;
`endif
               end
            end
            // Waiting for idle first keeps a residual UART busy from looking like an ack.
            PREP: begin
               if (!Tx_Busy) begin
                  Tx_Data <= cur_byte;
                  Tx_Send <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (Tx_Busy) begin
                  Tx_Send <= 1'b0;
                  state   <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!Tx_Busy) begin
                  if (idx == LAST_IDX) begin
                     Done  <= 1'b1;
                     Busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     idx   <= idx + {{(IDX_W-1){1'b0}}, 1'b1};
                     state <= PREP;
                     if (is_payload) begin
`ifdef HASH_TX_HEX_EN
                        nib_phase <= ~nib_phase;
                        if (nib_phase) begin
                           shreg <= shreg << 32'd8;
                        end
`else
                        shreg <= shreg << 32'd8;
`endif
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hash_tx_framer.sv
// Self-checking bench for hash_tx_framer: table-driven frames against a UART
// model with a fixed busy time, plus hand-written multi-cycle corner cases.
module tb_hash_tx_framer;

`ifdef HASH_TX_HEX_EN
   localparam int FMAX = 34;
`else
   localparam int FMAX = 18;
`endif
   localparam int BUDGET = 2000;

   typedef struct {
      logic [127:0]       data;
      logic               found;
      logic [8*FMAX-1:0]  exp;
   } vec_t;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Start;
   logic [127:0] Data;
   logic         Found;
   logic         Busy;
   logic         Done;
   logic [7:0]   Tx_Data;
   logic         Tx_Send;
   logic         Tx_Busy;

   int unsigned  ub_cnt = 0;
   logic         force_busy = 1'b0;
   int           done_cnt = 0;
   logic [7:0]   byte_q[$];
   int           total = 0;
   int           bad = 0;
   vec_t         vecs[4];

   always #5 Clk = ~Clk;

   hash_tx_framer dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Start   (Start),
      .Data    (Data),
      .Found   (Found),
      .Busy    (Busy),
      .Done    (Done),
      .Tx_Data (Tx_Data),
      .Tx_Send (Tx_Send),
      .Tx_Busy (Tx_Busy)
   );

   assign Tx_Busy = (ub_cnt != 0) || force_busy;

   // UART model: accepts a byte when idle and Tx_Send is high, then stays busy 10 cycles.
   always @(posedge Clk) begin
      if (ub_cnt != 0) begin
         ub_cnt <= ub_cnt - 1;
      end else if (Tx_Send && !force_busy) begin
         ub_cnt <= 10;
         byte_q.push_back(Tx_Data);
      end
      if (Done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_frame(input string name, input logic [8*FMAX-1:0] exp);
      logic [63:0] act;
      check({name, " len"}, 64'(byte_q.size()), 64'(FMAX));
      for (int i = 0; i < FMAX; i++) begin
         act = (i < byte_q.size()) ? {56'h0, byte_q[i]} : 64'h1FF;
         check($sformatf("%s byte%0d", name, i), act, {56'h0, exp[8*(FMAX-1-i) +: 8]});
      end
   endtask

   task automatic pulse_start(input logic [127:0] d, input logic f);
      @(negedge Clk);
      Start = 1'b1;
      Data  = d;
      Found = f;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int start_cnt;
      int c;
      start_cnt = done_cnt;
      for (c = 0; c < BUDGET; c++) begin
         @(negedge Clk);
         if (done_cnt != start_cnt) break;
      end
      check({name, " done"}, 64'(done_cnt - start_cnt), 64'd1);
   endtask

   task automatic wait_bytes(input int n);
      for (int c = 0; c < BUDGET; c++) begin
         if (byte_q.size() >= n) break;
         @(negedge Clk);
      end
      check("reach byte", 64'(byte_q.size() >= n), 64'd1);
   endtask

   initial begin
      logic sent;
      int   dc;

`ifdef HASH_TX_HEX_EN
      vecs[0] = '{128'h3A00_0000_0000_0000_0000_0000_0000_0000, 1'b1,
                  {8'h59, 8'h33, 8'h41, {30{8'h30}}, 8'h2C}};
      vecs[1] = '{128'h0, 1'b0, {8'h4E, {32{8'h30}}, 8'h2C}};
      vecs[2] = '{{16{8'h2C}}, 1'b1, {8'h59, {16{16'h3243}}, 8'h2C}};
      vecs[3] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0,
                  {8'h4E, 256'h30313233343536373839414243444546_46454443424139383736353433323130, 8'h2C}};
`else
      vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1,
                  {8'h59, 128'h00112233_44556677_8899AABB_CCDDEEFF, 8'h2C}};
      vecs[1] = '{128'h0, 1'b0, {8'h4E, 128'h0, 8'h2C}};
      vecs[2] = '{{16{8'h2C}}, 1'b1, {8'h59, {16{8'h2C}}, 8'h2C}};
      vecs[3] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0,
                  {8'h4E, 128'h0123456789ABCDEF_FEDCBA9876543210, 8'h2C}};
`endif

      Reset = 1'b1;
      Start = 1'b0;
      Data  = 128'h0;
      Found = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst Busy", {63'h0, Busy}, 64'd0);
      check("rst Done", {63'h0, Done}, 64'd0);
      check("rst Tx_Send", {63'h0, Tx_Send}, 64'd0);
      check("rst Tx_Data", {56'h0, Tx_Data}, 64'h00);
      Reset = 1'b0;
      @(negedge Clk);

      for (int v = 0; v < 4; v++) begin
         byte_q.delete();
         pulse_start(vecs[v].data, vecs[v].found);
         wait_done($sformatf("vec%0d", v));
         check_frame($sformatf("vec%0d", v), vecs[v].exp);
         dc = done_cnt;
         repeat (20) @(negedge Clk);
         check($sformatf("vec%0d Busy after", v), {63'h0, Busy}, 64'd0);
         check($sformatf("vec%0d single Done", v), 64'(done_cnt - dc), 64'd0);
      end

      // Latency: accept edge n, Tx_Send visible after edge n+1.
      byte_q.delete();
      pulse_start(vecs[1].data, vecs[1].found);
      check("lat Busy n+1", {63'h0, Busy}, 64'd1);
      check("lat Tx_Send n+1", {63'h0, Tx_Send}, 64'd0);
      @(negedge Clk);
      check("lat Tx_Send n+2", {63'h0, Tx_Send}, 64'd1);
      check("lat Tx_Data n+2", {56'h0, Tx_Data}, 64'h4E);
      wait_done("lat");
      check_frame("lat", vecs[1].exp);

      // UART busy held high at Start: nothing may be sent until it drops.
      byte_q.delete();
      force_busy = 1'b1;
      pulse_start(vecs[0].data, vecs[0].found);
      sent = 1'b0;
      repeat (30) begin
         @(negedge Clk);
         if (Tx_Send) sent = 1'b1;
      end
      check("stuck no send", {63'h0, sent}, 64'd0);
      force_busy = 1'b0;
      wait_done("stuck");
      check_frame("stuck", vecs[0].exp);

      // Start re-pulsed mid-frame must be ignored.
      byte_q.delete();
      pulse_start(vecs[0].data, vecs[0].found);
      wait_bytes(5);
      pulse_start(vecs[3].data, vecs[3].found);
      wait_done("restart");
      check_frame("restart", vecs[0].exp);
      dc = done_cnt;
      repeat (20) @(negedge Clk);
      check("restart idle", 64'(done_cnt - dc), 64'd0);

      // Reset during byte 5 aborts; a fresh frame follows from the status byte.
      byte_q.delete();
      pulse_start(vecs[3].data, vecs[3].found);
      wait_bytes(5);
      Reset = 1'b1;
      @(negedge Clk);
      check("abort Tx_Send", {63'h0, Tx_Send}, 64'd0);
      check("abort Busy", {63'h0, Busy}, 64'd0);
      check("abort Done", {63'h0, Done}, 64'd0);
      Reset = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (ub_cnt == 0) break;
         @(negedge Clk);
      end
      @(negedge Clk);
      byte_q.delete();
      pulse_start(vecs[2].data, vecs[2].found);
      wait_done("fresh");
      check_frame("fresh", vecs[2].exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hash_tx_framer.md
Name: hash_tx_framer

Overview:
- Transmit-side counterpart of the hash receive path.
- Captures a 128-bit hash/result word plus a found/not-found flag on a start pulse.
- Serialises the capture as a framed byte stream into the UART transmitter through the Tx_Data/Tx_Send/Tx_Busy handshake: status byte, NUM_BYTES payload bytes MSB-first, then terminator.
- Sits between the top-level controller/comparator and UART1's transmit port.

Parameters:
- NUM_BYTES, 16: payload bytes per frame; DATA_W = NUM_BYTES*8.
- TERM_BYTE, 8'h2C: frame terminator (',').
- FOUND_CHAR, 8'h59: status byte sent when Found=1 ('Y').
- NOTFOUND_CHAR, 8'h4E: status byte sent when Found=0 ('N').

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Data  in  DATA_W  payload; captured when Start is accepted.
- Found  in  1  result flag; captured with Data.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse after the terminator byte completes.
- Tx_Data  out  8  byte to UART.
- Tx_Send  out  1  UART send request.
- Tx_Busy  in  1  UART transmitter busy.

Behaviour:
- Reset is synchronous, active-high, on Clk. Reset values: Busy=0, Done=0, Tx_Send=0, Tx_Data=8'h00, state=IDLE, byte index=0. Reset mid-frame aborts the frame immediately; a byte already handed to the UART may still complete.
- States:
  - IDLE: if Start=1, register Data into a shift register, register Found, set index=0, Busy<=1, go PREP. Start is ignored in every other state.
  - PREP: wait for Tx_Busy=0, so a residual UART transfer is never mistaken for an acknowledge. Then Tx_Data<=current byte, Tx_Send<=1, go SEND.
  - SEND: hold Tx_Send=1 and Tx_Data stable until Tx_Busy=1 is sampled. Then Tx_Send<=0, go WAIT_DONE.
  - WAIT_DONE: wait for Tx_Busy=0. If the last byte was TERM_BYTE: Done<=1 for exactly 1 cycle, Busy<=0, go IDLE. Otherwise index+1, go PREP.
- Byte order:
  - index 0 = status byte.
  - index 1..NUM_BYTES = Data[DATA_W-1 -: 8] first, via left shift of the capture register.
  - Last index = TERM_BYTE. Total frame = NUM_BYTES+2 bytes.
- Payload bytes equal to TERM_BYTE are sent unescaped; the receiver frames by count.
- Latency: Start at cycle n with Tx_Busy=0 gives Tx_Send=1 at cycle n+2. Each byte takes 2 Clk overhead plus UART time.
- Index counter is wide enough for 2*NUM_BYTES+2 with no wrap. Done and Start coinciding is impossible, because Done is produced while the block is leaving busy.
- Tx_Busy stuck high holds the block in PREP/WAIT_DONE indefinitely; there is no timeout.

Optional Feature:
- Macro HASH_TX_HEX_EN.
- Defined: each payload byte is sent as two upper-case ASCII hex characters, high nibble first (0x3A -> '3','A'). Status and terminator bytes are sent unchanged. Frame = 2*NUM_BYTES+2 bytes.
- Undefined: raw binary payload, frame = NUM_BYTES+2 bytes. The nibble phase bit and converter are absent.

Decomposition:
- Package vadar_uart_pkg holds:
  - TERM_BYTE, FOUND_CHAR, NOTFOUND_CHAR constants.
  - Tx framer state enum (IDLE, PREP, SEND, WAIT_DONE).
  - Frame-length function of NUM_BYTES and the hex mode.
- One sub-module, hex_nibble_ascii: 4-bit nibble to 8-bit ASCII '0'-'9','A'-'F'. Instantiated only under HASH_TX_HEX_EN.

Test Plan:
- Raw mode, UART model with 10-cycle busy: Data=128'h00112233_44556677_8899AABB_CCDDEEFF, Found=1, Start pulse -> Tx_Data sequence 59,00,11,...,FF,2C (18 sends); Done pulses once; Busy low afterwards.
- Found=0, Data=0 -> 4E, sixteen 00, 2C; Tx_Send at cycle n+2 after Start.
- Tx_Busy held high for 30 cycles at Start -> no Tx_Send until Tx_Busy falls; first byte then sent correctly.
- Start re-pulsed mid-frame with different Data -> ignored; original frame completes unchanged.
- Reset asserted during byte 5 -> next cycle Tx_Send=0, Busy=0, Done=0; a following Start sends a full fresh frame from the status byte.
- HASH_TX_HEX_EN, Data byte 0 = 8'h3A, rest 0 -> 59,'3','A','0','0',...,2C (34 sends).
